hazard_forward_unit: RTL

Control-side counterpart of the EX-stage forwarding multiplexers in the 5-stage pipeline. It tracks destination-register metadata through ID/EX, EX/MEM and MEM/WB shadow registers and drives the 2-bit ForwardA/ForwardB selects that those muxes consume. It also detects load-use hazards and issues a one-cycle stall/bubble. It sits beside the pipeline registers and is fed from the ID stage decode.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/fwd_select.sv | 30 +++
 rtl/hazard_forward_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forward-select codes, hazard FSM encoding, register-index width.
package pipeline_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned FWD_W      = 2;

  localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB = 2'b01;
  localparam logic [FWD_W-1:0] FWD_EX = 2'b10;

  typedef enum logic [0:0] {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// Forward-select comparator for one EX operand; EX/MEM (youngest) beats MEM/WB, x0 never forwards.
module fwd_select
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_we,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_we,
  output logic [FWD_W-1:0]  o_fwd
);

  logic w_ex_hit;
  logic w_wb_hit;

  assign w_ex_hit = i_ex_we && (i_ex_rd != '0) && (i_ex_rd == i_rs);
  assign w_wb_hit = i_wb_we && (i_wb_rd != '0) && (i_wb_rd == i_rs);

  always_comb begin
    o_fwd = FWD_RF;
    if (w_ex_hit) begin
      o_fwd = FWD_EX;
    end else if (w_wb_hit) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage forwarding select and load-use stall control with ID/EX, EX/MEM, MEM/WB shadow state.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_forward_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [FWD_W-1:0]  ForwardA,
  output logic [FWD_W-1:0]  ForwardB,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  fwd_cnt
`endif
);

  logic [REG_AW-1:0] r_idex_rs1;
  logic [REG_AW-1:0] r_idex_rs2;
  logic [REG_AW-1:0] r_idex_rd;
  logic              r_idex_we;
  logic              r_idex_mr;
  logic [REG_AW-1:0] r_exmem_rd;
  logic              r_exmem_we;
  logic [REG_AW-1:0] r_memwb_rd;
  logic              r_memwb_we;

  hz_state_t r_state;
  hz_state_t w_state_nxt;
  logic      w_hazard;
  logic      w_stall;

  assign w_hazard = id_valid && r_idex_mr && (r_idex_rd != '0) &&
                    ((r_idex_rd == id_rs1) || (r_idex_rd == id_rs2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= HZ_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A flush in the same cycle kills the dependent instruction, so it wins over the stall.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HZ_RUN:   if (w_hazard && !flush) w_state_nxt = HZ_STALL;
      HZ_STALL: w_state_nxt = HZ_RUN;
      default:  w_state_nxt = HZ_RUN;
    endcase
  end

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      HZ_RUN:  w_stall = w_hazard && !flush;
      default: w_stall = 1'b0;
    endcase
  end

  assign pc_write     = !w_stall;
  assign if_id_write  = !w_stall;
  assign id_ex_bubble = w_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idex_rs1 <= '0;
      r_idex_rs2 <= '0;
      r_idex_rd  <= '0;
      r_idex_we  <= 1'b0;
      r_idex_mr  <= 1'b0;
      r_exmem_rd <= '0;
      r_exmem_we <= 1'b0;
      r_memwb_rd <= '0;
      r_memwb_we <= 1'b0;
    end else begin
      if (flush || w_stall) begin
        r_idex_rs1 <= '0;
        r_idex_rs2 <= '0;
        r_idex_rd  <= '0;
        r_idex_we  <= 1'b0;
        r_idex_mr  <= 1'b0;
      end else begin
        r_idex_rs1 <= id_valid ? id_rs1 : '0;
        r_idex_rs2 <= id_valid ? id_rs2 : '0;
        r_idex_rd  <= id_valid ? id_rd  : '0;
        r_idex_we  <= id_valid && id_reg_write;
        r_idex_mr  <= id_valid && id_mem_read;
      end
      r_exmem_rd <= r_idex_rd;
      r_exmem_we <= r_idex_we;
      r_memwb_rd <= r_exmem_rd;
      r_memwb_we <= r_exmem_we;
    end
  end

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .i_rs    (r_idex_rs1),
    .i_ex_rd (r_exmem_rd),
    .i_ex_we (r_exmem_we),
    .i_wb_rd (r_memwb_rd),
    .i_wb_we (r_memwb_we),
    .o_fwd   (ForwardA)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .i_rs    (r_idex_rs2),
    .i_ex_rd (r_exmem_rd),
    .i_ex_we (r_exmem_we),
    .i_wb_rd (r_memwb_rd),
    .i_wb_we (r_memwb_we),
    .o_fwd   (ForwardB)
  );

`ifdef HAZARD_PERF_EN
  logic w_fwd_any;
  assign w_fwd_any = (ForwardA != FWD_RF) || (ForwardB != FWD_RF);

  // Saturating counters: hazard stalls only (flush bubbles never raise w_stall).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (w_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (w_fwd_any && (fwd_cnt != '1)) fwd_cnt <= fwd_cnt + CNT_W'(1);
    end
  end
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W == 0);
`endif

endmodule
